// File: rtl/chacha_pkg.sv
// Shared ChaCha constants: word width, quarterround rotation amounts, inverse-QR FSM encodings.
// The forward quarterround uses the same rotation constants.
package chacha_pkg;

    localparam int WORD = 32;

    localparam int unsigned R16 = 16;
    localparam int unsigned R12 = 12;
    localparam int unsigned R8  = 8;
    localparam int unsigned R7  = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int unsigned n);
        rotr = (x >> n) | (x << (WORD - n));
    endfunction

endpackage

// File: rtl/chacha_inv_qr_step.sv
// One inverse quarterround half-step, selected by step_idx_i; purely combinational.
// Both updates in a half-step read the pre-step values, so a-b sees the b from the prior half-step.
module chacha_inv_qr_step
    import chacha_pkg::*;
(
    input  logic [WORD-1:0] a_i,
    input  logic [WORD-1:0] b_i,
    input  logic [WORD-1:0] c_i,
    input  logic [WORD-1:0] d_i,
    input  logic [1:0]      step_idx_i,
    output logic [WORD-1:0] a_o,
    output logic [WORD-1:0] b_o,
    output logic [WORD-1:0] c_o,
    output logic [WORD-1:0] d_o
);

    always_comb begin
        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        d_o = d_i;
        case (step_idx_i)
            2'd0: begin
                b_o = rotr(b_i, R7) ^ c_i;
                c_o = c_i - d_i;
            end
            2'd1: begin
                d_o = rotr(d_i, R8) ^ a_i;
                a_o = a_i - b_i;
            end
            2'd2: begin
                b_o = rotr(b_i, R12) ^ c_i;
                c_o = c_i - d_i;
            end
            default: begin
                d_o = rotr(d_i, R16) ^ a_i;
                a_o = a_i - b_i;
            end
        endcase
    end

endmodule

// File: rtl/chacha_inv_qr.sv
// Iterative inverse ChaCha quarterround; result valid 4*ITERATIONS/UNROLL cycles after accept.
// Result is held in DONE until out_ready; in_ready only in IDLE, no same-cycle bypass.
module chacha_inv_qr
    import chacha_pkg::*;
#(
    parameter int ITERATIONS = 1,
    parameter int UNROLL     = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] a_in,
    input  logic [WORD-1:0] b_in,
    input  logic [WORD-1:0] c_in,
    input  logic [WORD-1:0] d_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] a_out,
    output logic [WORD-1:0] b_out,
    output logic [WORD-1:0] c_out,
    output logic [WORD-1:0] d_out,
    output logic            busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || ITERATIONS < 1 || ITERATIONS > 255) begin : g_param_err
            $error("chacha_inv_qr: UNROLL must be 1, 2 or 4 and ITERATIONS 1..255");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [7:0]      iter_q, iter_d;
    logic [WORD-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

    logic [WORD-1:0] ch_a [UNROLL+1];
    logic [WORD-1:0] ch_b [UNROLL+1];
    logic [WORD-1:0] ch_c [UNROLL+1];
    logic [WORD-1:0] ch_d [UNROLL+1];

    assign ch_a[0] = a_q;
    assign ch_b[0] = b_q;
    assign ch_c[0] = c_q;
    assign ch_d[0] = d_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        chacha_inv_qr_step u_step (
            .a_i        (ch_a[k]),
            .b_i        (ch_b[k]),
            .c_i        (ch_c[k]),
            .d_i        (ch_d[k]),
            .step_idx_i (step_q + 2'(k)),
            .a_o        (ch_a[k+1]),
            .b_o        (ch_b[k+1]),
            .c_o        (ch_c[k+1]),
            .d_o        (ch_d[k+1])
        );
    end

    // Carry out of the 2-bit step counter marks the end of one full inverse quarterround.
    logic [2:0] step_sum;
    logic [8:0] iter_inc;
    assign step_sum = {1'b0, step_q} + 3'(UNROLL);
    assign iter_inc = {1'b0, iter_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        iter_d  = iter_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = c_in;
                    d_d     = d_in;
                    step_d  = 2'd0;
                    iter_d  = 8'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d    = ch_a[UNROLL];
                b_d    = ch_b[UNROLL];
                c_d    = ch_c[UNROLL];
                d_d    = ch_d[UNROLL];
                step_d = step_sum[1:0];
                if (step_sum[2]) begin
                    iter_d = iter_inc[7:0];
                    if (iter_inc == 9'(ITERATIONS)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            iter_q  <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            iter_q  <= iter_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign c_out     = c_q;
    assign d_out     = d_q;

endmodule

// File: tb/tb_chacha_inv_qr.sv
// Bench for chacha_inv_qr: several parameterisations, checked against a forward-quarterround model.
module tb_chacha_inv_qr;

    localparam int N = 5;
    localparam int IT_P [N] = '{1, 1, 1, 3, 255};
    localparam int UN_P [N] = '{1, 2, 4, 1, 4};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid [N];
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic        in_ready_w [N];
    logic        out_valid_w [N];
    logic        busy_w [N];
    logic [31:0] a_w [N], b_w [N], c_w [N], d_w [N];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        chacha_inv_qr #(.ITERATIONS(IT_P[g]), .UNROLL(UN_P[g])) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_w[g]),
            .a_in      (a_in),
            .b_in      (b_in),
            .c_in      (c_in),
            .d_in      (d_in),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .a_out     (a_w[g]),
            .b_out     (b_w[g]),
            .c_out     (c_w[g]),
            .d_out     (d_w[g]),
            .busy      (busy_w[g])
        );
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Forward ChaCha quarterround on {a,b,c,d}.
    function automatic logic [127:0] fwd_qr(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = s;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] fwd_n(input logic [127:0] s, input int n);
        logic [127:0] t = s;
        for (int i = 0; i < n; i++) t = fwd_qr(t);
        return t;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] get_out(input int g);
        return {a_w[g], b_w[g], c_w[g], d_w[g]};
    endfunction

    // Offer one word set to instance g, then count cycles to out_valid (-1 on timeout).
    task automatic start_and_wait(input int g, input logic [127:0] s, output int lat);
        {a_in, b_in, c_in, d_in} = s;
        in_valid[g] = 1'b1;
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (out_valid_w[g]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < N; g++) begin
            n_chk++;
            if ({in_ready_w[g], out_valid_w[g], busy_w[g]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b expected 100", g, {in_ready_w[g], out_valid_w[g], busy_w[g]});
            end
            n_chk++;
            if (get_out(g) !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", g, get_out(g));
            end
        end
    endtask

    task automatic test_rfc();
        logic [127:0] inp = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
        logic [127:0] exp = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
        int lat;
        for (int g = 0; g < 3; g++) begin
            start_and_wait(g, inp, lat);
            n_chk++;
            if (lat !== 4 / UN_P[g]) begin
                n_fail++;
                $display("FAIL rfc_latency[U=%0d]: got %0d expected %0d", UN_P[g], lat, 4 / UN_P[g]);
            end
            n_chk++;
            if (get_out(g) !== exp) begin
                n_fail++;
                $display("FAIL rfc_result[U=%0d]: got %h expected %h", UN_P[g], get_out(g), exp);
            end
            n_chk++;
            if ({busy_w[g], in_ready_w[g]} !== 2'b10) begin
                n_fail++;
                $display("FAIL rfc_done_flags[U=%0d]: got %b expected 10", UN_P[g], {busy_w[g], in_ready_w[g]});
            end
            handshake();
            n_chk++;
            if ({in_ready_w[g], out_valid_w[g], busy_w[g]} !== 3'b100) begin
                n_fail++;
                $display("FAIL rfc_after_hs[U=%0d]: got %b expected 100", UN_P[g], {in_ready_w[g], out_valid_w[g], busy_w[g]});
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        int lat;
        for (int v = 0; v < 1000; v++) begin
            orig = rnd128();
            start_and_wait(3, fwd_n(orig, 3), lat);
            n_chk++;
            if (lat !== 12 || get_out(3) !== orig) begin
                n_fail++;
                $display("FAIL round_trip[%0d]: got %h lat %0d expected %h lat 12", v, get_out(3), lat, orig);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] orig = rnd128();
        int lat;
        start_and_wait(0, fwd_qr(orig), lat);
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = i[0];
            {a_in, b_in, c_in, d_in} = rnd128();
            @(posedge clk); #1;
            n_chk++;
            if ({out_valid_w[0], in_ready_w[0]} !== 2'b10 || get_out(0) !== orig) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld/rdy %b data %h expected 10 data %h", i, {out_valid_w[0], in_ready_w[0]}, get_out(0), orig);
            end
        end
        in_valid[0] = 1'b0;
        handshake();
        n_chk++;
        if ({out_valid_w[0], in_ready_w[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got vld/rdy %b expected 01", {out_valid_w[0], in_ready_w[0]});
        end
        @(posedge clk); #1;
        n_chk++;
        if ({out_valid_w[0], busy_w[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_single_hs: got vld/busy %b expected 00", {out_valid_w[0], busy_w[0]});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] orig = rnd128();
        int lat;
        {a_in, b_in, c_in, d_in} = fwd_qr(rnd128());
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_chk++;
        if ({busy_w[0], out_valid_w[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrun_busy: got busy/vld %b expected 10", {busy_w[0], out_valid_w[0]});
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({in_ready_w[0], out_valid_w[0], busy_w[0]} !== 3'b100 || get_out(0) !== 128'd0) begin
            n_fail++;
            $display("FAIL midrun_abort: got flags %b data %h expected 100 data 0", {in_ready_w[0], out_valid_w[0], busy_w[0]}, get_out(0));
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        start_and_wait(0, fwd_qr(orig), lat);
        n_chk++;
        if (lat !== 4 || get_out(0) !== orig) begin
            n_fail++;
            $display("FAIL midrun_recover: got %h lat %0d expected %h lat 4", get_out(0), lat, orig);
        end
        handshake();
    endtask

    task automatic test_corners();
        logic [127:0] ones = {4{32'hffffffff}};
        int lat;
        start_and_wait(0, 128'd0, lat);
        n_chk++;
        if (lat !== 4 || get_out(0) !== 128'd0) begin
            n_fail++;
            $display("FAIL zeros: got %h lat %0d expected 0 lat 4", get_out(0), lat);
        end
        handshake();
        for (int g = 0; g < 4; g++) begin
            start_and_wait(g, fwd_n(ones, IT_P[g]), lat);
            n_chk++;
            if (lat !== 4 * IT_P[g] / UN_P[g] || get_out(g) !== ones) begin
                n_fail++;
                $display("FAIL ones[%0d]: got %h lat %0d expected %h lat %0d", g, get_out(g), lat, ones, 4 * IT_P[g] / UN_P[g]);
            end
            handshake();
        end
    endtask

    task automatic test_wrap();
        logic [127:0] orig;
        int lat;
        for (int v = 0; v < 3; v++) begin
            orig = rnd128();
            start_and_wait(4, fwd_n(orig, 255), lat);
            n_chk++;
            if (lat !== 255 || get_out(4) !== orig) begin
                n_fail++;
                $display("FAIL wrap255[%0d]: got %h lat %0d expected %h lat 255", v, get_out(4), lat, orig);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] orig;
        int lat;
        for (int v = 0; v < 20; v++) begin
            orig = rnd128();
            n_chk++;
            if (in_ready_w[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", v, in_ready_w[2]);
            end
            start_and_wait(2, fwd_qr(orig), lat);
            n_chk++;
            if (lat !== 1 || get_out(2) !== orig) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %h lat %0d expected %h lat 1", v, get_out(2), lat, orig);
            end
            handshake();
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) in_valid[g] = 1'b0;
        test_reset();
        test_rfc();
        test_round_trip();
        test_backpressure();
        test_reset_mid_run();
        test_corners();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
